// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants, FSM state type and digit-extraction helper for the
// octal seven-segment feeder.
package ssd_pkg;

   localparam int unsigned DIGITS  = 4;
   localparam int unsigned DIGIT_W = 3;
   localparam int unsigned VALUE_W = 12;
   localparam int unsigned SEL_W   = $clog2(DIGITS);

   typedef enum logic [2:0] {
      StIdle,
      StWr0,
      StWr1,
      StWr2,
      StWr3
   } state_t;

   // Octal digit n of a 12-bit word; n = 0 is the least significant digit.
   function automatic logic [DIGIT_W-1:0] get_digit(input logic [VALUE_W-1:0] word,
                                                    input logic [SEL_W-1:0]   n);
      return word[DIGIT_W*n +: DIGIT_W];
   endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// ssd_tick_gen: prescaler producing a one-cycle tick every TICK_DIV enabled clocks.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset (prescaler <= 0)
//   en    - count enable; the prescaler holds while low
//   clear - synchronous restart of the prescaler from 0
//   tick  - high for the cycle in which the prescaler sits at TICK_DIV-1 with en high
module ssd_tick_gen #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned PRE_W    = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clear,
   output logic tick
);

   localparam logic [PRE_W-1:0] PreLast = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] pre_q;

   assign tick = en && (pre_q == PreLast);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         pre_q <= '0;
      end else if (en) begin
         pre_q <= tick ? '0 : pre_q + 1'b1;
      end
   end

endmodule

// File: rtl/ssd_octal_feeder.sv
// ssd_octal_feeder: 12-bit up/down counter whose value is streamed as four octal
// digits into a seven-segment display write port after every value change.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   en, up            - count enable and direction for prescaled ticks
//   load, load_val    - one-cycle parallel load (wins over a same-cycle tick)
//   num, sel, wr      - display write port (digit, digit index, write strobe)
//   busy              - high while a four-cycle digit-write sequence runs
//   value             - current counter value
// Build option: define SSD_FEEDER_CHANGED_ONLY_EN to strobe wr only for digits
// that differ from the previously written value.
module ssd_octal_feeder
   import ssd_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned PRE_W    = 26
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               up,
   input  logic               load,
   input  logic [VALUE_W-1:0] load_val,
   output logic [DIGIT_W-1:0] num,
   output logic [SEL_W-1:0]   sel,
   output logic               wr,
   output logic               busy,
   output logic [VALUE_W-1:0] value
);

   state_t             state_q;
   logic [VALUE_W-1:0] shadow_q;
   logic               pending_q;
   logic               tick;

   logic [SEL_W-1:0]   nxt_sel;
   logic [VALUE_W-1:0] src_word;
   logic [DIGIT_W-1:0] nxt_num;
   logic               nxt_wr;

`ifdef SSD_FEEDER_CHANGED_ONLY_EN
   logic [VALUE_W-1:0] last_q;
   logic               last_valid_q;
`endif

   ssd_tick_gen #(
      .TICK_DIV (TICK_DIV),
      .PRE_W    (PRE_W)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clear (load),
      .tick  (tick)
   );

   // Digit presented on the edge that enters the next write state. Leaving IDLE
   // the shadow is being loaded this edge, so the digit comes from value directly.
   always_comb begin
      nxt_sel  = '0;
      src_word = shadow_q;
      unique case (state_q)
         StIdle:  src_word = value;
         StWr0:   nxt_sel  = 2'd1;
         StWr1:   nxt_sel  = 2'd2;
         StWr2:   nxt_sel  = 2'd3;
         default: nxt_sel  = '0;
      endcase
      nxt_num = get_digit(src_word, nxt_sel);
`ifdef SSD_FEEDER_CHANGED_ONLY_EN
      nxt_wr  = !last_valid_q || (nxt_num != get_digit(last_q, nxt_sel));
`else
      nxt_wr  = 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value     <= '0;
         pending_q <= 1'b1;  // forces an all-zero flush after reset
         state_q   <= StIdle;
         shadow_q  <= '0;
         num       <= '0;
         sel       <= '0;
         wr        <= 1'b0;
         busy      <= 1'b0;
`ifdef SSD_FEEDER_CHANGED_ONLY_EN
         last_q       <= '0;
         last_valid_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pending_q) begin
                  shadow_q  <= value;
                  pending_q <= 1'b0;
                  state_q   <= StWr0;
                  busy      <= 1'b1;
                  wr        <= nxt_wr;
                  sel       <= nxt_sel;
                  num       <= nxt_num;
               end
            end
            StWr0, StWr1, StWr2: begin
               state_q <= (state_q == StWr0) ? StWr1 :
                          (state_q == StWr1) ? StWr2 : StWr3;
               wr      <= nxt_wr;
               sel     <= nxt_sel;
               num     <= nxt_num;
            end
            StWr3: begin
               state_q <= StIdle;
               wr      <= 1'b0;
               busy    <= 1'b0;
`ifdef SSD_FEEDER_CHANGED_ONLY_EN
               last_q       <= shadow_q;
               last_valid_q <= 1'b1;
`endif
            end
            default: state_q <= StIdle;
         endcase

         // Placed after the FSM so a same-edge update re-arms pending even when
         // IDLE is consuming the previous request.
         if (load) begin
            value     <= load_val;
            pending_q <= 1'b1;
         end else if (tick) begin
            value     <= up ? value + 12'd1 : value - 12'd1;
            pending_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ssd_octal_feeder.sv
// Self-checking bench for ssd_octal_feeder: a behavioural model predicts value,
// busy and the digit writes each sequence must produce; a monitor pops and
// compares whenever the DUT strobes wr.
module tb_ssd_octal_feeder;

   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned PRE_W    = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        up = 1'b1;
   logic        load = 1'b0;
   logic [11:0] load_val = '0;
   logic [2:0]  num;
   logic [1:0]  sel;
   logic        wr;
   logic        busy;
   logic [11:0] value;

   always #5 clk = ~clk;

   ssd_octal_feeder #(
      .TICK_DIV (TICK_DIV),
      .PRE_W    (PRE_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .num      (num),
      .sel      (sel),
      .wr       (wr),
      .busy     (busy),
      .value    (value)
   );

   typedef struct packed {
      logic [1:0] sel;
      logic [2:0] num;
   } wr_t;

   wr_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int wr_count = 0;

   // Model state
   logic [11:0] m_val;
   logic [11:0] m_shadow;
   int          m_pre;
   int          m_phase;  // 0 = idle, 1..4 = writing digit m_phase-1
   bit          m_pend;
   bit          m_ok = 1'b0;
`ifdef SSD_FEEDER_CHANGED_ONLY_EN
   logic [11:0] m_last;
   bit          m_last_valid;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: advances once per clock edge from the sampled inputs.
   always @(posedge clk) begin
      if (reset) begin
         m_val   = '0;
         m_pre   = 0;
         m_pend  = 1'b1;
         m_phase = 0;
         exp_q.delete();
`ifdef SSD_FEEDER_CHANGED_ONLY_EN
         m_last       = '0;
         m_last_valid = 1'b0;
`endif
         m_ok = 1'b1;
      end else if (m_ok) begin
         if (m_phase == 0) begin
            if (m_pend) begin
               m_shadow = m_val;
               m_pend   = 1'b0;
               m_phase  = 1;
               for (int n = 0; n < 4; n++) begin
                  wr_t e;
                  int  d;
                  d     = (int'(m_shadow) >> (3 * n)) % 8;
                  e.sel = 2'(n);
                  e.num = 3'(d);
`ifdef SSD_FEEDER_CHANGED_ONLY_EN
                  if (!m_last_valid || d != (int'(m_last) >> (3 * n)) % 8) exp_q.push_back(e);
`else
                  exp_q.push_back(e);
`endif
               end
`ifdef SSD_FEEDER_CHANGED_ONLY_EN
               m_last       = m_shadow;
               m_last_valid = 1'b1;
`endif
            end
         end else if (m_phase == 4) begin
            m_phase = 0;
         end else begin
            m_phase++;
         end

         if (load) begin
            m_val  = load_val;
            m_pre  = 0;
            m_pend = 1'b1;
         end else if (en) begin
            if (m_pre == int'(TICK_DIV) - 1) begin
               m_pre  = 0;
               m_val  = 12'((int'(m_val) + (up ? 1 : 4095)) % 4096);
               m_pend = 1'b1;
            end else begin
               m_pre++;
            end
         end
      end
   end

   // Monitor: samples mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (m_ok) begin
         if (wr === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wr_unexpected actual sel=%0d num=%0d required no write", sel, num);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_sel", 32'(sel), 32'(e.sel));
               chk("wr_num", 32'(num), 32'(e.num));
            end
         end
         chk("busy", 32'(busy), 32'(m_phase != 0));
         chk("value", 32'(value), 32'(m_val));
`ifndef SSD_FEEDER_CHANGED_ONLY_EN
         chk("wr_window", 32'(wr), 32'(m_phase != 0));
`endif
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [11:0] v);
      @(negedge clk);
      load     = 1'b1;
      load_val = v;
      @(negedge clk);
      load     = 1'b0;
   endtask

   int c0;

   initial begin
      // Reset and all-zero flush
      cyc(2);
      reset = 1'b0;
      cyc(8);

      // Load
      c0 = wr_count;
      do_load(12'o5674);
      cyc(7);
      chk("load_value", 32'(value), 32'h0BBC);
      chk("load_pulses", 32'(wr_count - c0), 32'd4);

      // Count wrap up, then down
      do_load(12'o7777);
      en = 1'b1;
      up = 1'b1;
      cyc(4);
      chk("wrap_up", 32'(value), 32'h000);
      up = 1'b0;
      cyc(4);
      chk("wrap_down", 32'(value), 32'hFFF);
      en = 1'b0;
      cyc(8);

      // Coalesce: second load lands while the first sequence is in WR1
      c0 = wr_count;
      do_load(12'o0001);
      cyc(1);
      do_load(12'o0002);
      cyc(12);
      chk("coalesce_value", 32'(value), 32'h002);
`ifdef SSD_FEEDER_CHANGED_ONLY_EN
      chk("coalesce_pulses", 32'(wr_count - c0), 32'd5);
`else
      chk("coalesce_pulses", 32'(wr_count - c0), 32'd8);
`endif

      // Load and tick in the same cycle
      en = 1'b1;
      up = 1'b1;
      for (int i = 0; i < 10 && m_pre != int'(TICK_DIV) - 1; i++) @(negedge clk);
      if (m_pre != int'(TICK_DIV) - 1) begin
         checks++;
         errors++;
         $display("FAIL prio_wait actual pre=%0d required %0d", m_pre, TICK_DIV - 1);
      end
      load     = 1'b1;
      load_val = 12'o1234;
      @(negedge clk);
      load = 1'b0;
      chk("prio_value", 32'(value), 32'(12'o1234));
      cyc(3);
      chk("prio_restart", 32'(value), 32'(12'o1234));
      cyc(1);
      chk("prio_tick", 32'(value), 32'(12'o1235));
      en = 1'b0;
      cyc(8);

      // Reset while the sequence is in WR2
      c0 = wr_count;
      do_load(12'o4321);
      cyc(2);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_wr", 32'(wr), 32'd0);
      chk("abort_value", 32'(value), 32'd0);
      cyc(8);
      chk("abort_pulses", 32'(wr_count - c0), 32'd7);

`ifdef SSD_FEEDER_CHANGED_ONLY_EN
      c0 = wr_count;
      do_load(12'o0030);
      cyc(7);
      chk("changed_one", 32'(wr_count - c0), 32'd1);
      c0 = wr_count;
      do_load(12'o0030);
      cyc(7);
      chk("changed_none", 32'(wr_count - c0), 32'd0);
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         en       = 1'($urandom_range(0, 1));
         up       = 1'($urandom_range(0, 1));
         load     = ($urandom_range(0, 9) == 0);
         load_val = 12'($urandom);
         reset    = ($urandom_range(0, 99) == 0);
      end
      @(negedge clk);
      en    = 1'b0;
      load  = 1'b0;
      reset = 1'b0;
      cyc(12);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ssd_octal_feeder.md
Name: ssd_octal_feeder

Overview:
- Upstream source for the four-digit seven-segment display top. Drives its num/sel/wr write port.
- Holds a 12-bit counter value and advances it on a prescaled tick, or loads it from a parallel input.
- After every value change, it writes the four octal digits of the value into the display's digit registers, one digit per clock.

Parameters:
- TICK_DIV, 50000000, clocks per count tick (≥2); prescaler counts 0..TICK_DIV-1.
- PRE_W, 26, prescaler width; must satisfy 2^PRE_W ≥ TICK_DIV.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- en  input  1  count enable; prescaler holds while low
- up  input  1  count direction: 1 = increment, 0 = decrement
- load  input  1  one-cycle strobe: value <= load_val
- load_val  input  12  value to load
- num  output  3  octal digit to display write port
- sel  output  2  digit index; 0 = least significant digit
- wr  output  1  write strobe to display
- busy  output  1  high while the digit-write sequence runs
- value  output  12  current counter value

Behaviour:
- Reset (synchronous, active-high, checked at the clock edge):
  - value=0, prescaler=0, num=0, sel=0, wr=0, busy=0, state=IDLE.
  - pending=1, so one flush of all-zero digits follows reset release.
- Tick:
  - tick=1 when en=1 and prescaler==TICK_DIV-1; the prescaler then wraps to 0.
  - When en=0, the prescaler holds its count.
- Value update, in priority order:
  - reset, then load, then tick.
  - load: value<=load_val and prescaler<=0. A tick in the same cycle is discarded.
  - tick: value<=value+1 when up=1, value-1 when up=0. Modulo 4096 (0xFFF+1 -> 0x000, 0x000-1 -> 0xFFF).
  - Any value update sets pending=1.
- FSM states: IDLE, WR0, WR1, WR2, WR3.
  - IDLE: if pending, capture shadow<=value, clear pending, go to WR0. Otherwise stay.
  - WRn (n=0..3): wr=1, sel=n, num=shadow[3n+2:3n], busy=1. WRn -> WR(n+1), WR3 -> IDLE.
  - In IDLE: wr=0, busy=0, sel and num hold their last values.
- Latency:
  - value update at edge k -> state WR0 from edge k+1 -> wr high for exactly 4 consecutive cycles, sel 0,1,2,3.
  - busy falls at edge k+5.
- Consistency:
  - Digits always come from shadow, so a value change during a sequence never tears the displayed number.
  - An update during busy sets pending. A new sequence starts at the edge WR3 exits to IDLE +1 (IDLE visited one cycle).
  - Multiple updates during one sequence collapse into one pending; the latest value is written.
- Reset mid-sequence aborts it immediately: wr=0 on the next cycle, and the flush follows.
- Constraint: TICK_DIV ≥ 2 guarantees at most one tick per write sequence start window. No tick is lost in value, only coalesced in writes.

Optional Feature:
- Macro: SSD_FEEDER_CHANGED_ONLY_EN.
- Defined:
  - A 12-bit last_written register (reset to 0, plus a valid flag reset to 0) is kept.
  - In WRn, wr=1 only if valid=0 or the shadow digit n differs from last_written digit n. Otherwise wr=0.
  - sel/num still step, and sequence length stays 4 cycles.
  - At WR3 exit: last_written<=shadow, valid<=1.
- Undefined: all four digits are written every sequence.

Decomposition:
- Package ssd_pkg holds:
  - DIGITS=4, DIGIT_W=3, VALUE_W=12.
  - A state enum typedef (IDLE, WR0..WR3).
  - A function extracting digit n from a 12-bit word.
- One natural sub-module: ssd_tick_gen (prescaler producing the one-cycle tick, with en hold and synchronous clear on load). Parameter TICK_DIV.

Test Plan:
- Reset flush: TICK_DIV=4, pulse reset for 1 cycle -> wr high 4 cycles, sel 0,1,2,3, num 0,0,0,0; busy then 0.
- Load: load_val=12'o5674 -> value=0xBBC; wr sequence gives sel0 num4, sel1 num7, sel2 num6, sel3 num5.
- Count/wrap:
  - Load 12'o7777, en=1, up=1, TICK_DIV=4 -> after 4 clocks value=0, sequence writes 0,0,0,0.
  - Then up=0 -> next tick value=0xFFF.
- Coalesce: load 12'o0001, then load 12'o0002 during WR1 -> the first sequence completes with digits 1,0,0,0. After one IDLE cycle, a second sequence writes 2,0,0,0. Exactly 8 wr pulses total.
- Priority and reset abort:
  - load and tick in the same cycle -> value=load_val and the prescaler restarts from 0.
  - reset asserted in WR2 -> wr=0 the next cycle, value=0, flush sequence follows.
- With SSD_FEEDER_CHANGED_ONLY_EN: after the flush, load 12'o0030 -> exactly one wr pulse (sel1, num3). Loading 12'o0030 again -> zero wr pulses and busy still high for 4 cycles.
